// File: rtl/boron_pkg.sv
// boron_pkg: shared constants, S-box and FSM state type for the BORON engine
package boron_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, WHITEN, DONE} state_t;
  localparam logic [63:0] SBOX = 64'h6358F02DAC971B4E;
  localparam int KEY_ROT = 13;
  localparam int ROT0 = 1;
  localparam int ROT1 = 4;
  localparam int ROT2 = 7;
  localparam int ROT3 = 9;
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/boron_round.sv
// boron_round: one combinational BORON round plus the matching key-schedule step
module boron_round
  import boron_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [63:0]      data_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       cnt_i,
  output logic [63:0]      data_o,
  output logic [KEY_W-1:0] key_o
);
  localparam int ROT [4] = '{ROT0, ROT1, ROT2, ROT3};
  logic [63:0] x, s, b;
  logic [15:0] w [4];
  logic [KEY_W-1:0] kr;
  assign x = data_i ^ key_i[63:0];
  genvar i;
  for (i = 0; i < 16; i++) begin : g_sbox
    assign s[4*i +: 4] = sbox4(x[4*i +: 4]);
  end
  // block shuffle swaps the bytes of each word, then each word is rotated
  for (i = 0; i < 4; i++) begin : g_word
    assign b[16*i +: 16] = {s[16*i +: 8], s[16*i+8 +: 8]};
    assign w[i] = (b[16*i +: 16] << ROT[i]) | (b[16*i +: 16] >> (16 - ROT[i]));
  end
  assign data_o = {w[3] ^ w[0] ^ w[1], w[2] ^ w[3] ^ w[0], w[1] ^ w[2] ^ w[3], w[0] ^ w[1] ^ w[2]};
  assign kr = {key_i[KEY_W-KEY_ROT-1:0], key_i[KEY_W-1:KEY_W-KEY_ROT]};
  // rotated key gets nonlinear low nibble(s) and the round counter folded in
  always_comb begin
    key_o = kr;
    key_o[3:0] = sbox4(kr[3:0]);
    if (KEY_W == 128) key_o[7:4] = sbox4(kr[7:4]);
    key_o[63:59] = kr[63:59] ^ cnt_i;
  end
endmodule

// File: rtl/boron_core.sv
// boron_core: iterative BORON encryption engine with valid/ready on both sides
module boron_core
  import boron_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      plain_text,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      cipher_text,
  output logic             busy
);
  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key
    $error("boron_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("boron_core: ROUNDS must be 1..31");
  end
  state_t state, nxt;
  logic [4:0] cnt;
  logic [63:0] data_r, rd;
  logic [KEY_W-1:0] key_r, rk;
  logic accept;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state == ROUND || state == WHITEN;
  boron_round #(.KEY_W(KEY_W)) u_round (
    .data_i(data_r),
    .key_i (key_r),
    .cnt_i (cnt),
    .data_o(rd),
    .key_o (rk)
  );
  // next state; a finished block leaves DONE straight into a new one when offered
  always_comb begin
    nxt = state;
    nxt = state == IDLE   ? (accept ? ROUND : IDLE) :
          state == ROUND  ? (cnt == 5'(ROUNDS - 1) ? WHITEN : ROUND) :
          state == WHITEN ? DONE :
          !out_ready      ? DONE :
          in_valid        ? ROUND : IDLE;
  end
  // state register; reset aborts any block in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  // datapath: load on accept, one round per ROUND cycle, whiten into the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      data_r <= '0;
      key_r <= '0;
      cipher_text <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        data_r <= plain_text;
        key_r <= key;
        cnt <= '0;
      end else if (state == ROUND) begin
        data_r <= rd;
        key_r <= rk;
        cnt <= cnt + 5'd1;
      end
      if (state == WHITEN) begin
        cipher_text <= data_r ^ key_r[63:0];
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_boron_core.sv
// tb_boron_core: directed/randomized checks of boron_core against a behavioural cipher model
module tb_boron_core;
  logic clk = 0, rst = 0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_busy;
  logic [63:0] a_plain = 0, a_cipher;
  logic [79:0] a_key = 0;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_busy;
  logic [63:0] b_plain = 0, b_cipher;
  logic [127:0] b_key = 0;
  int checks = 0, errors = 0;
  int lat;
  logic [63:0] held;
  logic [63:0] ps [3];
  logic [79:0] ks [3];
  const int SB [16] = '{14, 4, 11, 1, 7, 9, 12, 10, 13, 2, 0, 15, 8, 5, 3, 6};
  const int RT [4] = '{1, 4, 7, 9};

  always #5 clk = ~clk;

  boron_core dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .plain_text(a_plain),
    .key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready), .cipher_text(a_cipher), .busy(a_busy)
  );
  boron_core #(.KEY_W(128), .ROUNDS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .plain_text(b_plain),
    .key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready), .cipher_text(b_cipher), .busy(b_busy)
  );

  function automatic logic [63:0] model(input logic [63:0] pt, input logic [127:0] k, input int kw, input int rounds);
    logic [63:0] d = pt, x;
    logic [127:0] kk = k;
    logic [127:0] m = (kw == 128) ? '1 : {48'd0, {80{1'b1}}};
    logic [15:0] w [4];
    for (int r = 0; r < rounds; r++) begin
      x = d ^ kk[63:0];
      for (int n = 0; n < 16; n++) x[4*n +: 4] = 4'(SB[x[4*n +: 4]]);
      for (int j = 0; j < 4; j++) begin
        w[j] = x[16*j +: 16];
        w[j] = {w[j][7:0], w[j][15:8]};
        w[j] = (w[j] << RT[j]) | (w[j] >> (16 - RT[j]));
      end
      for (int j = 0; j < 4; j++) d[16*j +: 16] = w[j] ^ w[(j+1)%4] ^ w[(j+2)%4];
      kk = ((kk << 13) | (kk >> (kw - 13))) & m;
      kk[3:0] = 4'(SB[kk[3:0]]);
      if (kw == 128) kk[7:4] = 4'(SB[kk[7:4]]);
      kk[63:59] = kk[63:59] ^ 5'(r);
    end
    return d ^ kk[63:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a;
    lat = 0;
    while (!a_out_valid && lat < 200) begin tick; lat++; end
  endtask

  task automatic run_a(input logic [63:0] pt, input logic [79:0] k, input string tag);
    a_plain = pt; a_key = k; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    wait_a;
    chk({tag, " latency"}, lat, 26);
    chk({tag, " cipher"}, a_cipher, model(pt, {48'd0, k}, 80, 25));
    a_out_ready = 1;
    tick;
    a_out_ready = 0;
    chk({tag, " drop"}, {a_out_valid, a_in_ready, a_busy}, 3'b010);
  endtask

  initial begin
    #2;
    chk("reset a", {a_in_ready, a_out_valid, a_busy, a_cipher}, {3'b100, 64'd0});
    chk("reset b", {b_in_ready, b_out_valid, b_busy, b_cipher}, {3'b100, 64'd0});
    tick;
    rst = 1;
    tick;
    run_a(64'd0, 80'd0, "zero");
    for (int i = 0; i < 3; i++)
      run_a({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)}, "rand");
    // inputs churn during the rounds, then the result is held under backpressure
    ps[0] = {$urandom, $urandom}; ks[0] = {$urandom, $urandom, 16'($urandom)};
    a_plain = ps[0]; a_key = ks[0]; a_in_valid = 1;
    tick;
    lat = 0;
    while (!a_out_valid && lat < 200) begin
      a_plain = ~a_plain; a_key = {$urandom, $urandom, 16'($urandom)};
      tick; lat++;
    end
    a_in_valid = 0;
    chk("toggle latency", lat, 26);
    chk("toggle cipher", a_cipher, model(ps[0], {48'd0, ks[0]}, 80, 25));
    held = model(ps[0], {48'd0, ks[0]}, 80, 25);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall", {a_out_valid, a_in_ready, a_busy, a_cipher}, {3'b100, held});
    end
    a_out_ready = 1;
    #1;
    chk("stall release ready", a_in_ready, 1'b1);
    tick;
    a_out_ready = 0;
    chk("after handshake idle", {a_out_valid, a_in_ready, a_busy}, 3'b010);
    // back-to-back blocks with in_valid and out_ready held high
    for (int j = 0; j < 3; j++) begin ps[j] = {$urandom, $urandom}; ks[j] = {$urandom, $urandom, 16'($urandom)}; end
    a_out_ready = 1; a_in_valid = 1; a_plain = ps[0]; a_key = ks[0];
    tick;
    for (int j = 0; j < 3; j++) begin
      wait_a;
      chk("b2b latency", lat, 26);
      chk("b2b cipher", a_cipher, model(ps[j], {48'd0, ks[j]}, 80, 25));
      chk("b2b in_ready", a_in_ready, 1'b1);
      if (j < 2) begin a_plain = ps[j+1]; a_key = ks[j+1]; end
      else a_in_valid = 0;
      tick;
      chk("b2b next", {a_out_valid, a_busy}, {1'b0, j < 2});
    end
    a_out_ready = 0;
    #1;
    chk("b2b end idle", a_in_ready, 1'b1);
    // asynchronous reset in the middle of round 12
    a_plain = {$urandom, $urandom}; a_key = {$urandom, $urandom, 16'($urandom)}; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    for (int i = 0; i < 12; i++) tick;
    chk("mid busy", a_busy, 1'b1);
    #2 rst = 0;
    #1;
    chk("mid reset", {a_out_valid, a_in_ready, a_busy, a_cipher}, {3'b010, 64'd0});
    tick;
    rst = 1;
    tick;
    run_a({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)}, "post reset");
    // 128-bit key, 4 rounds
    b_plain = '1; b_key = '1; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    lat = 0;
    while (!b_out_valid && lat < 50) begin tick; lat++; end
    chk("k128 latency", lat, 5);
    chk("k128 ones cipher", b_cipher, model(64'hFFFFFFFFFFFFFFFF, '1, 128, 4));
    tick;
    chk("k128 drop", {b_out_valid, b_in_ready}, 2'b01);
    b_plain = {$urandom, $urandom}; b_key = {$urandom, $urandom, $urandom, $urandom}; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    lat = 0;
    while (!b_out_valid && lat < 50) begin tick; lat++; end
    chk("k128 rand latency", lat, 5);
    chk("k128 rand cipher", b_cipher, model(b_plain, b_key, 128, 4));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
